// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module : mul_div_unit_pkg
// Brief  : Opcode constants, FSM state type and helpers for the M-extension unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam logic [4:0] ALU_MUL    = 5'h0a;
  localparam logic [4:0] ALU_MULH   = 5'h0b;
  localparam logic [4:0] ALU_MULHSU = 5'h0c;
  localparam logic [4:0] ALU_MULHU  = 5'h0d;
  localparam logic [4:0] ALU_DIV    = 5'h0e;
  localparam logic [4:0] ALU_DIVU   = 5'h0f;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_div_core.sv
// ============================================================================
// Module : mul_div_core
// Brief  : Radix-2 iterative datapath: shift-add multiply, restoring divide
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_core #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  is_div_i,
  input  logic [XLEN-1:0]       opa_i,
  input  logic [XLEN-1:0]       opb_i,
  output logic [2*XLEN-1:0]     prod_o,
  output logic [XLEN-1:0]       quot_o,
  output logic [XLEN-1:0]       rem_o
);

  // acc_q low half holds the multiplier (mul) or the dividend/quotient (div)
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opb_q;

  logic [XLEN:0]     w_sum;
  logic [XLEN+1:0]   w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_ge;

  always_comb begin
    acc_d   = acc_q;
    rem_d   = rem_q;
    w_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    w_shift = {rem_q, acc_q[XLEN-1]};
    w_ge    = (w_shift >= {2'b00, opb_q});
    w_diff  = w_shift[XLEN:0] - {1'b0, opb_q};
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, opa_i};
      rem_d = '0;
    end else if (step_i) begin
      if (is_div_i) begin
        rem_d = w_ge ? w_diff : w_shift[XLEN:0];
        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], w_ge};
      end else begin
        acc_d = {w_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      rem_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      if (load_i) begin
        opb_q <= opb_i;
      end
    end
  end

  assign prod_o = acc_q;
  assign quot_o = acc_q[XLEN-1:0];
  assign rem_o  = rem_q[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module : mul_div_unit
// Brief  : Multi-cycle RV32M execution unit: FSM, sign handling and fast paths
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      aluControl,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      op_q;
  logic            sa_q, sb_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic              w_sgn_a, w_sgn_b, w_div0, w_ovf, w_fast, w_accept, w_is_div_in;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_res, w_fix_res;
  logic [XLEN-1:0]   w_quot, w_rem, w_quot_n, w_rem_n;
  logic [2*XLEN-1:0] w_prod, w_prod_n;

  always_comb begin
    w_sgn_a     = ((aluControl == ALU_MULH) || (aluControl == ALU_MULHSU) ||
                   (aluControl == ALU_DIV)  || (aluControl == ALU_REM)) && srcA[XLEN-1];
    w_sgn_b     = ((aluControl == ALU_MULH) || (aluControl == ALU_DIV) ||
                   (aluControl == ALU_REM)) && srcB[XLEN-1];
    w_mag_a     = w_sgn_a ? -srcA : srcA;
    w_mag_b     = w_sgn_b ? -srcB : srcB;
    w_is_div_in = (aluControl >= ALU_DIV);
    w_div0      = w_is_div_in && (srcB == '0);
    w_ovf       = ((aluControl == ALU_DIV) || (aluControl == ALU_REM)) &&
                  (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
    w_fast      = w_div0 || w_ovf;
    w_accept    = (state_q == ST_IDLE) && start && is_md_op(aluControl);

    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = ((aluControl == ALU_DIV) || (aluControl == ALU_DIVU)) ? '1 : srcA;
    end else if (aluControl == ALU_DIV) begin
      w_fast_res = srcA;
    end
  end

  mul_div_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_accept && !w_fast),
    .step_i   (state_q == ST_CALC),
    .is_div_i (op_q >= ALU_DIV),
    .opa_i    (w_mag_a),
    .opb_i    (w_mag_b),
    .prod_o   (w_prod),
    .quot_o   (w_quot),
    .rem_o    (w_rem)
  );

  // Unsigned ops never set sa_q/sb_q, so negation is a no-op for them
  always_comb begin
    w_prod_n = (sa_q ^ sb_q) ? -w_prod : w_prod;
    w_quot_n = (sa_q ^ sb_q) ? -w_quot : w_quot;
    w_rem_n  = sa_q ? -w_rem : w_rem;
    case (op_q)
      ALU_MUL:                          w_fix_res = w_prod_n[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  w_fix_res = w_prod_n[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU:                w_fix_res = w_quot_n;
      default:                          w_fix_res = w_rem_n;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            op_q   <= aluControl;
            sa_q   <= w_sgn_a;
            sb_q   <= w_sgn_b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (w_fast) begin
              result_q <= w_fast_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              state_q  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_q <= w_fix_res;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module : tb_mul_div_unit
// Brief  : Directed self-checking bench for mul_div_unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  aluControl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(
    .XLEN(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start in the cycle after the call point; cycle k = k-th edge after acceptance
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int inject);
    int   lat;
    logic busy_ok;
    @(posedge clk); #1;
    start = 1'b1; aluControl = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; aluControl = ALU_DIVU; srcA = ~a; srcB = b ^ 32'h5a5a_5a5a;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      start = (k == inject);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, result, exp);
    chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  logic        seen_busy, seen_done;
  logic [31:0] r_prev;

  initial begin
    reset = 1'b1; start = 1'b0; aluControl = '0; srcA = '0; srcB = '0;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_op("mul",     ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh",    ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_op("mulhu",   ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    run_op("mulhsu",  ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("mulhu2",  ALU_MULHU,  32'h8000_0000, 32'd2,         32'h0000_0001, 34, 0);
    run_op("div",     ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
    run_op("rem",     ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
    run_op("divu",    ALU_DIVU,   32'd100,       32'd7,         32'd14,        34, 0);
    run_op("remu",    ALU_REMU,   32'd100,       32'd7,         32'd2,         34, 0);
    run_op("divnn",   ALU_DIV,    32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         34, 0);
    run_op("remnn",   ALU_REM,    32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34, 0);
    run_op("divubig", ALU_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, 0);
    run_op("div0",    ALU_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem0",    ALU_REM,    32'd5,         32'd0,         32'd5,         1,  0);
    run_op("divu0",   ALU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu0",   ALU_REMU,   32'd5,         32'd0,         32'd5,         1,  0);
    run_op("divovf",  ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("removf",  ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);
    run_op("mulinj",  ALU_MUL,    32'd3,         32'd5,         32'd15,        34, 10);

    // Invalid opcodes in IDLE must be ignored
    r_prev = result;
    seen_busy = 1'b0; seen_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; aluControl = 5'h00; srcA = 32'd9; srcB = 32'd3;
    @(posedge clk); #1;
    aluControl = 5'h12;
    for (int k = 0; k < 5; k++) begin
      if (busy) seen_busy = 1'b1;
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("invalid busy", {31'd0, seen_busy}, 32'd0);
    chk("invalid done", {31'd0, seen_done}, 32'd0);
    chk("invalid result", result, r_prev);

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    start = 1'b1; aluControl = ALU_DIVU; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst quiet", {31'd0, seen_done}, 32'd0);
    run_op("postrst", ALU_DIVU, 32'd1000, 32'd3, 32'd333, 34, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
